// File: rtl/qbert_pkg.sv
// qbert_pkg: shared types and helpers for the Qbert jump controller.
//   jump_dir_t  - diagonal jump directions
//   state_t     - jump sequencer states
//   APEX_IDX    - cube index of the pyramid apex (rank 2)
//   idx_to_rp / rp_to_idx - cube index <-> {rank, position} mapping
//     rank 0: idx 0,1,2   rank 1: idx 3,4   rank 2: idx 5
package qbert_pkg;

    typedef enum logic [1:0] {
        DIR_UP_A = 2'd0,
        DIR_UP_B = 2'd1,
        DIR_DN_A = 2'd2,
        DIR_DN_B = 2'd3
    } jump_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_JUMP,
        ST_LAND,
        ST_FALL,
        ST_DEAD
    } state_t;

    localparam logic [2:0] APEX_IDX     = 3'd5;
    localparam logic [5:0] VISITED_INIT = 6'b100000;

    // Returns {rank[1:0], pos[1:0]}.
    function automatic logic [3:0] idx_to_rp(input logic [2:0] idx);
        logic [3:0] rp;
        if (idx < 3'd3)
            rp = {2'd0, idx[1:0]};
        else if (idx < 3'd5)
            rp = {2'd1, 2'(idx - 3'd3)};
        else
            rp = {2'd2, 2'd0};
        return rp;
    endfunction

    function automatic logic [2:0] rp_to_idx(input logic [1:0] r, input logic [1:0] p);
        logic [2:0] idx;
        case (r)
            2'd0:    idx = {1'b0, p};
            2'd1:    idx = 3'd3 + {2'b00, p[0]};
            default: idx = APEX_IDX;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/qbert_cube_coord.sv
// qbert_cube_coord: combinational rest box of Qbert's sprite on cube (r,p),
// derived from the live map geometry. All arithmetic is modulo 11/10 bits.
// Ports:
//   r, p                          in   cube rank / position
//   XLENGTH, XDIAG_DEMI,
//   RANK1_X_OFFSET                in   11-bit map geometry
//   YDIAG_DEMI, RANK1_Y_OFFSET    in   10-bit map geometry
//   x0, x1 / y0, y1               out  sprite box corners
module qbert_cube_coord #(
    parameter logic [10:0] QB_SIZE = 11'd24
) (
    input  logic [1:0]  r,
    input  logic [1:0]  p,
    input  logic [10:0] XLENGTH,
    input  logic [10:0] XDIAG_DEMI,
    input  logic [10:0] RANK1_X_OFFSET,
    input  logic [9:0]  YDIAG_DEMI,
    input  logic [9:0]  RANK1_Y_OFFSET,
    output logic [10:0] x0,
    output logic [10:0] x1,
    output logic [9:0]  y0,
    output logic [9:0]  y1
);

    logic [10:0] xstep;
    logic [10:0] cx;
    logic [9:0]  cy;

    always_comb begin
        xstep = XLENGTH + XDIAG_DEMI;
        cx    = RANK1_X_OFFSET - xstep * {9'b0, r} - {10'b0, (r != 2'd0)};
        cy    = RANK1_Y_OFFSET + YDIAG_DEMI * {8'b0, r}
              + (YDIAG_DEMI << 1) * {8'b0, p} + {9'b0, (p != 2'd0)};
        x0    = cx - QB_SIZE;
        x1    = cx - 11'd1;
        y0    = cy + YDIAG_DEMI - QB_SIZE[10:1];
        y1    = y0 + QB_SIZE[9:0] - 10'd1;
    end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl: moves Qbert across the 6-cube pyramid, animating the
// sprite box per frame tick, tracking visited cubes and detecting falls.
// Optional macro QBERT_JUMP_ARC_EN adds a hop arc to X during JUMP.
// Ports:
//   CLK_33, reset (sync, active-high), frame_tick, jump_req, jump_dir,
//   restart, map geometry inputs                         -> inputs
//   QBERT_POSITION_X0/X1/Y0/Y1 sprite box, cube_idx, visited, busy,
//   jump_done (landing pulse), fell (DEAD), all_visited  -> outputs
module qbert_jump_ctrl
    import qbert_pkg::*;
#(
    parameter int unsigned JUMP_LOG2 = 3,
    parameter logic [10:0] QB_SIZE   = 11'd24,
    parameter logic [10:0] FALL_STEP = 11'd16,
    parameter logic [10:0] X_LIMIT   = 11'd800,
    parameter logic [10:0] ARC_STEP  = 11'd4
) (
    input  logic        CLK_33,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        jump_req,
    input  logic [1:0]  jump_dir,
    input  logic        restart,
    input  logic [10:0] XLENGTH,
    input  logic [10:0] XDIAG_DEMI,
    input  logic [10:0] RANK1_X_OFFSET,
    input  logic [9:0]  YDIAG_DEMI,
    input  logic [9:0]  RANK1_Y_OFFSET,
    output logic [10:0] QBERT_POSITION_X0,
    output logic [10:0] QBERT_POSITION_X1,
    output logic [9:0]  QBERT_POSITION_Y0,
    output logic [9:0]  QBERT_POSITION_Y1,
    output logic [2:0]  cube_idx,
    output logic [5:0]  visited,
    output logic        busy,
    output logic        jump_done,
    output logic        fell,
    output logic        all_visited
);

`ifdef QBERT_JUMP_ARC_EN
    localparam bit ARC_EN = 1'b1;
`else
    localparam bit ARC_EN = 1'b0;
`endif

    localparam logic [JUMP_LOG2:0] K_END = {1'b1, {JUMP_LOG2{1'b0}}};

    state_t state, state_n;
    logic [2:0]  cube_idx_q, tgt_idx_q, nxt_idx;
    logic [5:0]  visited_q;
    logic        tgt_valid_q, nxt_valid, accept;
    logic [10:0] px0, px1;
    logic [9:0]  py0, py1;
    logic signed [10:0] sx, dx;
    logic signed [9:0]  sy, dy;
    logic [JUMP_LOG2:0] k, krem, kmin;
    logic [10:0] arc;
    logic [3:0]  cur_rp, tgt_rp;
    logic signed [2:0] tr, tp;
    logic [10:0] cur_x0, cur_x1, tgt_x0, tgt_x1;
    logic [9:0]  cur_y0, cur_y1, tgt_y0, tgt_y1;

    assign cur_rp = idx_to_rp(cube_idx_q);
    assign tgt_rp = idx_to_rp(tgt_idx_q);

    qbert_cube_coord #(.QB_SIZE(QB_SIZE)) u_cur (
        .r(cur_rp[3:2]), .p(cur_rp[1:0]),
        .XLENGTH(XLENGTH), .XDIAG_DEMI(XDIAG_DEMI), .RANK1_X_OFFSET(RANK1_X_OFFSET),
        .YDIAG_DEMI(YDIAG_DEMI), .RANK1_Y_OFFSET(RANK1_Y_OFFSET),
        .x0(cur_x0), .x1(cur_x1), .y0(cur_y0), .y1(cur_y1)
    );

    qbert_cube_coord #(.QB_SIZE(QB_SIZE)) u_tgt (
        .r(tgt_rp[3:2]), .p(tgt_rp[1:0]),
        .XLENGTH(XLENGTH), .XDIAG_DEMI(XDIAG_DEMI), .RANK1_X_OFFSET(RANK1_X_OFFSET),
        .YDIAG_DEMI(YDIAG_DEMI), .RANK1_Y_OFFSET(RANK1_Y_OFFSET),
        .x0(tgt_x0), .x1(tgt_x1), .y0(tgt_y0), .y1(tgt_y1)
    );

    // Target cube from the current cube and the requested direction; signed
    // 3-bit rank/pos so off-pyramid moves (-1 or 3) are detectable.
    always_comb begin
        tr = signed'({1'b0, cur_rp[3:2]});
        tp = signed'({1'b0, cur_rp[1:0]});
        case (jump_dir_t'(jump_dir))
            DIR_UP_A: begin tr = tr + 3'sd1; tp = tp - 3'sd1; end
            DIR_UP_B: begin tr = tr + 3'sd1; end
            DIR_DN_A: begin tr = tr - 3'sd1; end
            default:  begin tr = tr - 3'sd1; tp = tp + 3'sd1; end
        endcase
        nxt_valid = (tr >= 3'sd0) && (tr <= 3'sd2) && (tp >= 3'sd0) && (tp <= 3'sd2 - tr);
        nxt_idx   = rp_to_idx(tr[1:0], tp[1:0]);
    end

    assign dx = signed'(tgt_x0 - cur_x0);
    assign dy = signed'(tgt_y0 - cur_y0);

    assign all_visited = &visited_q;
    assign accept      = (state == ST_IDLE) && jump_req && !all_visited;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_CALC;
            ST_CALC: state_n = ST_JUMP;
            ST_JUMP: begin
                if (!tgt_valid_q)    state_n = ST_FALL;
                else if (k == K_END) state_n = ST_LAND;
            end
            ST_LAND: state_n = ST_IDLE;
            ST_FALL: if (px0 > X_LIMIT) state_n = ST_DEAD;
            default: state_n = ST_DEAD;
        endcase
    end

    always_ff @(posedge CLK_33) begin
        if (reset || restart)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge CLK_33) begin
        if (reset || restart) begin
            cube_idx_q  <= APEX_IDX;
            visited_q   <= VISITED_INIT;
            tgt_idx_q   <= APEX_IDX;
            tgt_valid_q <= 1'b1;
            px0 <= '0; px1 <= '0; py0 <= '0; py1 <= '0;
            sx  <= '0; sy  <= '0;
            k   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    tgt_idx_q   <= nxt_idx;
                    tgt_valid_q <= nxt_valid;
                end
                ST_CALC: begin
                    px0 <= cur_x0; px1 <= cur_x1;
                    py0 <= cur_y0; py1 <= cur_y1;
                    sx  <= dx >>> JUMP_LOG2;
                    sy  <= dy >>> JUMP_LOG2;
                    k   <= '0;
                end
                ST_JUMP: if (tgt_valid_q) begin
                    // Snap uses live geometry, so parameter changes mid-jump
                    // only affect the landing point, not the latched step.
                    if (k == K_END) begin
                        px0 <= tgt_x0; px1 <= tgt_x1;
                        py0 <= tgt_y0; py1 <= tgt_y1;
                    end else if (frame_tick) begin
                        px0 <= px0 + sx; px1 <= px1 + sx;
                        py0 <= py0 + sy; py1 <= py1 + sy;
                        k   <= k + 1'b1;
                    end
                end
                ST_LAND: begin
                    cube_idx_q            <= tgt_idx_q;
                    visited_q[tgt_idx_q]  <= 1'b1;
                end
                ST_FALL: if (frame_tick && !(px0 > X_LIMIT)) begin
                    px0 <= px0 + FALL_STEP;
                    px1 <= px1 + FALL_STEP;
                end
                default: ;
            endcase
        end
    end

    // Hop arc: ARC_STEP * min(k, 2^JUMP_LOG2 - k), zero at both ends.
    always_comb begin
        krem = K_END - k;
        kmin = (k < krem) ? k : krem;
        arc  = ARC_EN ? ARC_STEP * 11'(kmin) : 11'd0;
    end

    always_comb begin
        QBERT_POSITION_X0 = cur_x0;
        QBERT_POSITION_X1 = cur_x1;
        QBERT_POSITION_Y0 = cur_y0;
        QBERT_POSITION_Y1 = cur_y1;
        if (state == ST_JUMP) begin
            QBERT_POSITION_X0 = px0 - arc;
            QBERT_POSITION_X1 = px1 - arc;
            QBERT_POSITION_Y0 = py0;
            QBERT_POSITION_Y1 = py1;
        end else if (state inside {ST_LAND, ST_FALL, ST_DEAD}) begin
            QBERT_POSITION_X0 = px0;
            QBERT_POSITION_X1 = px1;
            QBERT_POSITION_Y0 = py0;
            QBERT_POSITION_Y1 = py1;
        end
    end

    assign cube_idx  = cube_idx_q;
    assign visited   = visited_q;
    assign busy      = state inside {ST_CALC, ST_JUMP, ST_LAND, ST_FALL};
    assign jump_done = (state == ST_LAND);
    assign fell      = (state == ST_DEAD);

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
module tb_qbert_jump_ctrl;

    logic        CLK_33 = 1'b0;
    logic        reset, frame_tick, jump_req, restart;
    logic [1:0]  jump_dir;
    logic [10:0] XLENGTH, XDIAG_DEMI, RANK1_X_OFFSET;
    logic [9:0]  YDIAG_DEMI, RANK1_Y_OFFSET;
    logic [10:0] X0, X1;
    logic [9:0]  Y0, Y1;
    logic [2:0]  cube_idx;
    logic [5:0]  visited;
    logic        busy, jump_done, fell, all_visited;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK_33 = ~CLK_33;

    qbert_jump_ctrl dut (
        .CLK_33(CLK_33), .reset(reset), .frame_tick(frame_tick),
        .jump_req(jump_req), .jump_dir(jump_dir), .restart(restart),
        .XLENGTH(XLENGTH), .XDIAG_DEMI(XDIAG_DEMI), .RANK1_X_OFFSET(RANK1_X_OFFSET),
        .YDIAG_DEMI(YDIAG_DEMI), .RANK1_Y_OFFSET(RANK1_Y_OFFSET),
        .QBERT_POSITION_X0(X0), .QBERT_POSITION_X1(X1),
        .QBERT_POSITION_Y0(Y0), .QBERT_POSITION_Y1(Y1),
        .cube_idx(cube_idx), .visited(visited), .busy(busy),
        .jump_done(jump_done), .fell(fell), .all_visited(all_visited)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic clk1();
        @(posedge CLK_33);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        clk1();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!jump_done && n < 12) begin
            clk1();
            n++;
        end
        check(tag, jump_done, 1);
    endtask

    task automatic do_jump(input logic [1:0] dir, input logic [2:0] exp_idx, input string tag);
        jump_dir = dir;
        jump_req = 1'b1;
        clk1();
        jump_req = 1'b0;
        clk1();
        for (int i = 0; i < 8; i++) tick();
        wait_done(tag);
        clk1();
        check(tag, cube_idx, exp_idx);
    endtask

    initial begin
        int n;
        reset = 1'b1; frame_tick = 1'b0; jump_req = 1'b0; restart = 1'b0; jump_dir = 2'd0;
        XLENGTH = 11'd55; XDIAG_DEMI = 11'd30; RANK1_X_OFFSET = 11'd600;
        YDIAG_DEMI = 10'd50; RANK1_Y_OFFSET = 10'd90;
        clk1(); clk1();
        reset = 1'b0;
        clk1();

        // Reset state: apex rest box
        check("rst_x0", X0, 405);
        check("rst_x1", X1, 428);
        check("rst_y0", Y0, 228);
        check("rst_y1", Y1, 251);
        check("rst_idx", cube_idx, 5);
        check("rst_visited", visited, 6'b100000);
        check("rst_busy", busy, 0);
        check("rst_fell", fell, 0);
        check("rst_done", jump_done, 0);
        check("rst_allv", all_visited, 0);

        // Geometry change in IDLE: box follows combinationally
        RANK1_X_OFFSET = 11'd610;
        #1;
        check("param_x0", X0, 415);
        RANK1_X_OFFSET = 11'd600;
        #1;

        // DN_A from apex, with ignored jump_req during JUMP
        jump_dir = 2'd2; jump_req = 1'b1;
        clk1();
        jump_req = 1'b0;
        check("calc_busy", busy, 1);
        clk1();
        check("jump_x0_k0", X0, 405);
        tick();
        check("jump_x0_k1", X0, 415);
        check("jump_x1_k1", X1, 438);
        check("jump_y0_k1", Y0, 221);
        check("jump_y1_k1", Y1, 244);
        jump_dir = 2'd0; jump_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        jump_req = 1'b0;
        frame_tick = 1'b1;
        clk1();
        frame_tick = 1'b0;
        check("jump_x0_k8", X0, 485);
        check("jump_y0_k8", Y0, 172);
        wait_done("land1_done");
        check("snap_x0", X0, 490);
        check("snap_x1", X1, 513);
        check("snap_y0", Y0, 178);
        check("snap_y1", Y1, 201);
        clk1();
        check("land1_done_clr", jump_done, 0);
        check("land1_busy", busy, 0);
        check("land1_idx", cube_idx, 3);
        check("land1_visited", visited, 6'b101000);
        check("land1_x0", X0, 490);

        // restart mid-JUMP
        jump_dir = 2'd2; jump_req = 1'b1;
        clk1();
        jump_req = 1'b0;
        clk1();
        for (int i = 0; i < 3; i++) tick();
        restart = 1'b1;
        clk1();
        restart = 1'b0;
        check("rs_x0", X0, 405);
        check("rs_y0", Y0, 228);
        check("rs_visited", visited, 6'b100000);
        check("rs_busy", busy, 0);
        check("rs_idx", cube_idx, 5);

        // UP_A from apex: fall off the pyramid
        jump_dir = 2'd0; jump_req = 1'b1;
        clk1();
        jump_req = 1'b0;
        clk1(); clk1();
        check("fall_busy", busy, 1);
        check("fall_x0_start", X0, 405);
        tick();
        check("fall_x0_t1", X0, 421);
        check("fall_x1_t1", X1, 444);
        n = 1;
        while (!fell && n < 40) begin
            tick();
            n++;
        end
        check("fall_ticks", n, 25);
        check("dead_fell", fell, 1);
        check("dead_x0", X0, 805);
        check("dead_x1", X1, 828);
        check("dead_busy", busy, 0);
        jump_dir = 2'd2; jump_req = 1'b1;
        clk1(); clk1(); clk1();
        jump_req = 1'b0;
        check("dead_ignore_fell", fell, 1);
        check("dead_ignore_busy", busy, 0);
        restart = 1'b1;
        clk1();
        restart = 1'b0;
        check("dead_restart_fell", fell, 0);
        check("dead_restart_x0", X0, 405);

        // Tour all six cubes
        do_jump(2'd2, 3'd3, "tour1");
        do_jump(2'd2, 3'd0, "tour2");
        do_jump(2'd1, 3'd3, "tour3");
        do_jump(2'd3, 3'd1, "tour4");
        do_jump(2'd1, 3'd4, "tour5");
        do_jump(2'd3, 3'd2, "tour6");
        check("tour_visited", visited, 6'b111111);
        check("tour_allv", all_visited, 1);
        check("tour_x0", X0, 576);
        check("tour_y0", Y0, 329);
        check("tour_y1", Y1, 352);
        jump_dir = 2'd0; jump_req = 1'b1;
        clk1();
        jump_req = 1'b0;
        check("allv_ignore_busy", busy, 0);
        clk1();
        check("allv_ignore_busy2", busy, 0);
        check("allv_ignore_idx", cube_idx, 2);
        restart = 1'b1;
        clk1();
        restart = 1'b0;
        check("final_visited", visited, 6'b100000);
        check("final_allv", all_visited, 0);
        check("final_idx", cube_idx, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
